// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared types and default constants for the multi-port
//                register file.
//                  rf_state_e : sweep FSM states (RF_INIT, RF_RUN)
//                  RF_DATA_W  : default register width
//                  RF_ADDR_W  : default address width
//                  RF_NUM_RD  : default read-port count
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NUM_RD = 2;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp_if
//  Description : Bus bundle between decode/writeback and the register file.
//                  we0/waddr0/wdata0 : write port 0
//                  we1/waddr1/wdata1 : write port 1 (higher priority)
//                  raddr / rdata     : packed read ports, port k at slice k
//                  rsv_valid/rsv_addr: mark a register pending
//                  pend              : pending flag per read port
//                  init_done         : clear sweep finished
//                master = requester side, slave = register file side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_mp_if
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = RF_NUM_RD
) ();

  logic                     we0;
  logic [ADDR_W-1:0]        waddr0;
  logic [DATA_W-1:0]        wdata0;
  logic                     we1;
  logic [ADDR_W-1:0]        waddr1;
  logic [DATA_W-1:0]        wdata1;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     rsv_valid;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [NUM_RD-1:0]        pend;
  logic                     init_done;

  modport master (
    output we0, waddr0, wdata0,
    output we1, waddr1, wdata1,
    output raddr,
    output rsv_valid, rsv_addr,
    input  rdata, pend, init_done
  );

  modport slave (
    input  we0, waddr0, wdata0,
    input  we1, waddr1, wdata1,
    input  raddr,
    input  rsv_valid, rsv_addr,
    output rdata, pend, init_done
  );

endinterface : regfile_mp_if
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : rf_scoreboard
//  Description : Per-register pending bits for in-flight producers.
//                  clk, rst_n      : clock, async active-low reset
//                  en_i            : updates allowed (RUN state)
//                  clr0_*/clr1_*   : retiring writes clear their register
//                  set_i/set_addr_i: reservation marks a register pending
//                  raddr_i/pend_o  : NUM_RD lookup ports (registered state)
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     en_i,
  input  wire logic                     clr0_i,
  input  wire logic [ADDR_W-1:0]        clr0_addr_i,
  input  wire logic                     clr1_i,
  input  wire logic [ADDR_W-1:0]        clr1_addr_i,
  input  wire logic                     set_i,
  input  wire logic [ADDR_W-1:0]        set_addr_i,
  input  wire logic [NUM_RD*ADDR_W-1:0] raddr_i,
  output logic      [NUM_RD-1:0]        pend_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic             w_set_ok;

  // Entry 0 never becomes pending when it is hardwired to zero.
  assign w_set_ok = set_i && !((ZERO_REG != 0) && (set_addr_i == '0));

  // Clears are applied before the set so a reservation landing on the same
  // register as a retiring write survives: it belongs to the newer producer.
  always_comb begin
    pend_d = pend_q;
    if (en_i) begin
      if (clr0_i) pend_d[clr0_addr_i] = 1'b0;
      if (clr1_i) pend_d[clr1_addr_i] = 1'b0;
      if (w_set_ok) pend_d[set_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_lookup
    assign pend_o[k] = pend_q[raddr_i[k*ADDR_W +: ADDR_W]];
  end

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-port register file with two prioritised write ports,
//                optional write-to-read bypass, optional hardwired-zero
//                entry 0, pending scoreboard and a post-reset clear sweep.
//                  clk, rst_n : clock, async active-low reset
//                  rf_if      : regfile_mp_if.slave bus (write, read,
//                               reservation ports, pend, init_done)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  regfile_mp_if.slave rf_if
);

  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] SWEEP_LAST = (ADDR_W + 1)'(DEPTH - 1);

  rf_state_e             state_q;
  logic [ADDR_W:0]       sweep_q;     // one extra bit: no wrap at DEPTH-1
  logic                  init_done_q;
  logic [DATA_W-1:0]     mem_q [DEPTH];

  logic                  w_run;
  logic                  w_we0;
  logic                  w_we1;
  logic                  w_st0;
  logic                  w_st1;
  logic [NUM_RD-1:0]     w_pend;

  assign w_run = (state_q == RF_RUN);
  assign w_we0 = rf_if.we0 && w_run;
  assign w_we1 = rf_if.we1 && w_run;

  // Storage writes to entry 0 are dropped in zero-register mode so the
  // swept zero stays put regardless of what the datapath retires there.
  assign w_st0 = w_we0 && !((ZERO_REG != 0) && (rf_if.waddr0 == '0));
  assign w_st1 = w_we1 && !((ZERO_REG != 0) && (rf_if.waddr1 == '0));

  // --------------------------------------------------------------------------
  // Sweep FSM: walks every entry once after reset, then parks in RUN.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RF_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        RF_INIT: begin
          sweep_q <= sweep_q + (ADDR_W + 1)'(1);
          if (sweep_q == SWEEP_LAST) begin
            state_q     <= RF_RUN;
            init_done_q <= 1'b1;
          end
        end
        RF_RUN: begin
          state_q <= RF_RUN;
        end
        default: begin
          state_q     <= RF_INIT;
          sweep_q     <= '0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Storage. No reset here on purpose: the sweep is what clears it, and reads
  // are forced to zero until the sweep has completed.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state_q == RF_INIT) begin
      mem_q[sweep_q[ADDR_W-1:0]] <= '0;
    end else begin
      if (w_st0) mem_q[rf_if.waddr0] <= rf_if.wdata0;
      // Port 1 is assigned last so it wins on an address collision.
      if (w_st1) mem_q[rf_if.waddr1] <= rf_if.wdata1;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports with optional bypass. Later assignments take precedence:
  // port 1 bypass over port 0, zero register over bypass, INIT over all.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;

    assign w_ra = rf_if.raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_rd = mem_q[w_ra];
      if ((BYPASS != 0) && w_we0 && (rf_if.waddr0 == w_ra)) w_rd = rf_if.wdata0;
      if ((BYPASS != 0) && w_we1 && (rf_if.waddr1 == w_ra)) w_rd = rf_if.wdata1;
      if ((ZERO_REG != 0) && (w_ra == '0))                  w_rd = '0;
      if (!w_run)                                           w_rd = '0;
    end

    assign rf_if.rdata[k*DATA_W +: DATA_W] = w_rd;
  end

  // --------------------------------------------------------------------------
  // Pending scoreboard
  // --------------------------------------------------------------------------
  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (w_run),
    .clr0_i      (w_we0),
    .clr0_addr_i (rf_if.waddr0),
    .clr1_i      (w_we1),
    .clr1_addr_i (rf_if.waddr1),
    .set_i       (rf_if.rsv_valid),
    .set_addr_i  (rf_if.rsv_addr),
    .raddr_i     (rf_if.raddr),
    .pend_o      (w_pend)
  );

  assign rf_if.pend      = w_run ? w_pend : '0;
  assign rf_if.init_done = init_done_q;

endmodule : regfile_mp
`default_nettype wire
